// File: rtl/fifo_stream_adapter_if.sv
// Valid/ready stream carrying words out of fifo_stream_adapter.
// The adapter drives through the master modport; the consumer uses the slave modport.
interface fifo_stream_adapter_if #(
  parameter int DATA_WIDE = 64
);
  logic                 m_valid;
  logic                 m_ready;
  logic [DATA_WIDE-1:0] m_data;

  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/fifo_stream_adapter.sv
// Drains a one-cycle-latency FIFO read port into a registered valid/ready stream.
// A 2-entry skid buffer gives full throughput; m_data comes straight from a storage register.
module fifo_stream_adapter #(
  parameter int DATA_WIDE = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fifo_empty,
  input  logic [DATA_WIDE-1:0] fifo_dout,
  output logic                 fifo_rd_en,
  input  logic                 flush,
  output logic [1:0]           occ,
  fifo_stream_adapter_if.master m
);

  logic [DATA_WIDE-1:0] mem_q [2];
  logic                 head_q;
  logic [1:0]           occ_q;
  logic                 inflight_q;

  logic                 pop;
  logic                 tail_idx;
  logic [2:0]           level;
  logic [2:0]           occ_next;

  // level counts words held after this cycle's pop plus the word already on its way;
  // issuing a read only while it is below 2 keeps occ + inflight <= 2 at all times.
  always_comb begin
    pop        = 1'b0;
    level      = '0;
    occ_next   = '0;
    tail_idx   = 1'b0;
    fifo_rd_en = 1'b0;

    pop        = (occ_q != 2'd0) & m.m_ready;
    level      = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
    occ_next   = flush ? 3'd0 : level;
    tail_idx   = head_q ^ occ_q[0];
    fifo_rd_en = rst_n & ~fifo_empty & ~flush & (level < 3'd2);
  end

  assign m.m_valid = (occ_q != 2'd0);
  assign m.m_data  = mem_q[head_q];
  assign occ       = occ_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= '0;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
    end else if (flush) begin
      // Flush wins over a simultaneous pop, so the pop is not applied to head.
      occ_q      <= '0;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
    end else begin
      occ_q      <= occ_next[1:0];
      inflight_q <= fifo_rd_en;
      if (pop) begin
        head_q <= ~head_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (inflight_q && !flush) begin
      mem_q[tail_idx] <= fifo_dout;
    end
  end

  a_occ_range: assert property (@(posedge clk) disable iff (!rst_n) occ_next <= 3'd2);
  a_no_rd_empty: assert property (@(posedge clk) disable iff (!rst_n) fifo_rd_en |-> !fifo_empty);

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Directed bench for fifo_stream_adapter with a behavioural one-cycle-latency FIFO model.
module tb_fifo_stream_adapter;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rd_en;
  logic          flush = 1'b0;
  logic [1:0]    occ;

  int checks = 0;
  int errors = 0;

  fifo_stream_adapter_if #(.DATA_WIDE(DW)) m_if ();

  fifo_stream_adapter #(.DATA_WIDE(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .occ        (occ),
    .m          (m_if)
  );

  always #5 clk = ~clk;

  // Upstream FIFO model: data appears on fifo_dout the cycle after a read.
  logic [DW-1:0] mem [64];
  logic [5:0]    wr_ptr = '0;
  logic [5:0]    rd_ptr = '0;
  logic          rd_while_empty = 1'b0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fifo_empty) rd_while_empty <= 1'b1;
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 6'd1;
    end
  end

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if (m_if.m_valid !== 1'b0 || fifo_rd_en !== 1'b0 || occ !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b rd_en=%b occ=%0d, want 0 0 0", m_if.m_valid, fifo_rd_en, occ);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_if.m_ready = 1'b0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (m_if.m_valid !== 1'b0 || fifo_rd_en !== 1'b0 || occ !== 2'd0) begin
        errors++;
        $display("FAIL idle[%0d]: valid=%b rd_en=%b occ=%0d, want 0 0 0", i, m_if.m_valid, fifo_rd_en, occ);
      end
    end
  endtask

  task automatic test_stream();
    @(negedge clk);
    m_if.m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    #1;
    checks++;
    if (fifo_rd_en !== 1'b1 || m_if.m_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_first_rd: rd_en=%b valid=%b, want 1 0", fifo_rd_en, m_if.m_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (m_if.m_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_latency: valid=%b one cycle after rd_en, want 0", m_if.m_valid);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (m_if.m_valid !== 1'b1 || m_if.m_data !== DW'(i + 1)) begin
        errors++;
        $display("FAIL stream_word[%0d]: valid=%b data=%h, want 1 %h", i, m_if.m_valid, m_if.m_data, DW'(i + 1));
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (m_if.m_valid !== 1'b0 || occ !== 2'd0) begin
      errors++;
      $display("FAIL stream_drained: valid=%b occ=%0d, want 0 0", m_if.m_valid, occ);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_w [3];
    exp_w[0] = DW'(64'hA);
    exp_w[1] = DW'(64'hB);
    exp_w[2] = DW'(64'hC);
    @(negedge clk);
    m_if.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(exp_w[i]);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (occ !== 2'd2 || m_if.m_valid !== 1'b1 || m_if.m_data !== exp_w[0] || fifo_rd_en !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: occ=%0d valid=%b data=%h rd_en=%b, want 2 1 %h 0",
                 k, occ, m_if.m_valid, m_if.m_data, fifo_rd_en, exp_w[0]);
      end
      @(negedge clk);
    end
    m_if.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (m_if.m_valid !== 1'b1 || m_if.m_data !== exp_w[i]) begin
        errors++;
        $display("FAIL bp_release[%0d]: valid=%b data=%h, want 1 %h", i, m_if.m_valid, m_if.m_data, exp_w[i]);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (m_if.m_valid !== 1'b0 || occ !== 2'd0) begin
      errors++;
      $display("FAIL bp_drained: valid=%b occ=%0d, want 0 0", m_if.m_valid, occ);
    end
  endtask

  task automatic test_alternating();
    int exp_idx;
    exp_idx = 0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) push(DW'(64'h100 + i));
    for (int c = 0; c < 200 && exp_idx < 16; c++) begin
      m_if.m_ready = (c % 2 == 0);
      #1;
      if (m_if.m_valid && m_if.m_ready) begin
        checks++;
        if (m_if.m_data !== DW'(64'h100 + exp_idx)) begin
          errors++;
          $display("FAIL alt_word[%0d]: data=%h, want %h", exp_idx, m_if.m_data, DW'(64'h100 + exp_idx));
        end
        exp_idx++;
      end
      checks++;
      if (occ > 2'd2) begin
        errors++;
        $display("FAIL alt_occ: occ=%0d, want <= 2", occ);
      end
      @(negedge clk);
    end
    checks++;
    if (exp_idx != 16) begin
      errors++;
      $display("FAIL alt_count: got %0d words, want 16", exp_idx);
    end
    m_if.m_ready = 1'b1;
    #1;
    checks++;
    if (m_if.m_valid !== 1'b0) begin
      errors++;
      $display("FAIL alt_drained: valid=%b, want 0", m_if.m_valid);
    end
  endtask

  task automatic test_flush();
    int waited;
    // Full buffer flushed with m_ready also high: the flush must win.
    @(negedge clk);
    m_if.m_ready = 1'b0;
    push(DW'(64'hE0));
    push(DW'(64'hE1));
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (occ !== 2'd2) begin
      errors++;
      $display("FAIL flush_pre_full: occ=%0d, want 2", occ);
    end
    @(negedge clk);
    flush = 1'b1;
    m_if.m_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    m_if.m_ready = 1'b0;
    #1;
    checks++;
    if (occ !== 2'd0 || m_if.m_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_full: occ=%0d valid=%b, want 0 0", occ, m_if.m_valid);
    end
    // Flush in the cycle D0 returns: D0 dropped, no new read issued.
    @(negedge clk);
    for (int i = 0; i < 4; i++) push(DW'(64'hD0 + i));
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++;
    if (fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL flush_rd_en: rd_en=%b during flush, want 0", fifo_rd_en);
    end
    @(negedge clk);
    flush = 1'b0;
    m_if.m_ready = 1'b1;
    #1;
    checks++;
    if (occ !== 2'd0 || m_if.m_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_inflight: occ=%0d valid=%b, want 0 0", occ, m_if.m_valid);
    end
    waited = 0;
    while (!m_if.m_valid && waited < 10) begin
      @(negedge clk);
      #1;
      waited++;
    end
    for (int i = 1; i < 4; i++) begin
      if (i > 1) begin
        @(negedge clk);
        #1;
      end
      checks++;
      if (m_if.m_valid !== 1'b1 || m_if.m_data !== DW'(64'hD0 + i)) begin
        errors++;
        $display("FAIL flush_resume[%0d]: valid=%b data=%h, want 1 %h", i, m_if.m_valid, m_if.m_data, DW'(64'hD0 + i));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int waited;
    @(negedge clk);
    m_if.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(DW'(64'hF0 + i));
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (occ !== 2'd1) begin
      errors++;
      $display("FAIL rst_pre_occ: occ=%0d, want 1", occ);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_if.m_valid !== 1'b0 || occ !== 2'd0 || fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: valid=%b occ=%0d rd_en=%b, want 0 0 0", m_if.m_valid, occ, fifo_rd_en);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_if.m_ready = 1'b1;
    #1;
    waited = 0;
    while (!m_if.m_valid && waited < 10) begin
      @(negedge clk);
      #1;
      waited++;
    end
    // F0 and F1 were read before reset and are lost; streaming restarts at F2.
    for (int i = 2; i < 6; i++) begin
      if (i > 2) begin
        @(negedge clk);
        #1;
      end
      checks++;
      if (m_if.m_valid !== 1'b1 || m_if.m_data !== DW'(64'hF0 + i)) begin
        errors++;
        $display("FAIL rst_resume[%0d]: valid=%b data=%h, want 1 %h", i, m_if.m_valid, m_if.m_data, DW'(64'hF0 + i));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    m_if.m_ready = 1'b0;
    test_reset();
    test_idle();
    test_stream();
    test_backpressure();
    test_alternating();
    test_flush();
    test_async_reset();
    checks++;
    if (rd_while_empty !== 1'b0) begin
      errors++;
      $display("FAIL rd_en_while_empty: flag=%b, want 0", rd_while_empty);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
